// File: rtl/vga_char_pipe.sv
// Text-mode pixel pipeline: scans the 80x30 text/colour RAMs, fetches 8x16 glyphs from the font ROM
// and serialises them into registered IRGB pixels with a blinking underline cursor and aligned sync.
module vga_char_pipe #(
  parameter int unsigned H_LAST   = 799,
  parameter int unsigned COLS     = 80,
  parameter int unsigned V_FRAME  = 480,
  parameter int unsigned CUR_ROW0 = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hx,
  input  logic [9:0]  vy,
  input  logic        n_pixel_ena,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] vram_addr,
  input  logic [7:0]  text_d,
  input  logic [7:0]  color_d,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_d,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [3:0]  vga_irgb,
  output logic        vga_hsync,
  output logic        vga_vsync
);

  localparam logic [9:0] H_LAST_C    = 10'(H_LAST);
  localparam logic [9:0] V_FRAME_C   = 10'(V_FRAME);
  localparam logic [9:0] ADV_LIMIT_C = 10'((COLS - 1) * 8);
  localparam logic [3:0] CUR_ROW0_C  = 4'(CUR_ROW0);

  logic [4:0]  row_r;
  logic [3:0]  scan_r;
  logic [6:0]  col_a_r;
  logic [11:0] vram_addr_r;
  logic [7:0]  char_q_r;
  logic [7:0]  attr_q_r;
  logic [6:0]  col_q_r;
  logic [7:0]  attr_cur_r;
  logic [7:0]  shift_r;
  logic [3:0]  pix_r;
  logic [4:0]  frame_cnt_r;
  logic [3:0]  vga_irgb_r;
  logic        vga_hsync_r;
  logic        vga_vsync_r;
  logic        hit_s;

  // Line setup seeds the row base as row*64 + row*16; afterwards the address steps once per 8-pixel cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r       <= 5'd0;
      scan_r      <= 4'd0;
      col_a_r     <= 7'd0;
      vram_addr_r <= 12'd0;
    end else if (hx == H_LAST_C) begin
      row_r       <= vy[8:4];
      scan_r      <= vy[3:0];
      col_a_r     <= 7'd0;
      vram_addr_r <= {1'b0, vy[8:4], 6'b000000} + {3'b000, vy[8:4], 4'b0000};
    end else if ((hx[2:0] == 3'd7) && (hx < ADV_LIMIT_C)) begin
      vram_addr_r <= vram_addr_r + 12'd1;
      col_a_r     <= col_a_r + 7'd1;
    end
  end

  // Stage 1: capture character and attribute mid-cell, once the RAM address has settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_q_r <= 8'd0;
      attr_q_r <= 8'd0;
      col_q_r  <= 7'd0;
    end else if (hx[2:0] == 3'd3) begin
      char_q_r <= text_d;
      attr_q_r <= color_d;
      col_q_r  <= col_a_r;
    end
  end

  // Cursor hit for the cell currently in stage 1.
  always_comb begin
    hit_s = 1'b0;
    if (cursor_en && frame_cnt_r[4] && (col_q_r == cursor_col) &&
        (row_r == cursor_row) && (scan_r >= CUR_ROW0_C)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Stage 2 and serialiser: the load edge also captures the last bit of the previous glyph into pix.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= 8'd0;
      attr_cur_r <= 8'd0;
      pix_r      <= 4'd0;
    end else begin
      if (hx[2:0] == 3'd6) begin
        shift_r    <= font_d | {8{hit_s}};
        attr_cur_r <= attr_q_r;
      end else begin
        shift_r <= {shift_r[6:0], 1'b0};
      end
      pix_r <= shift_r[7] ? attr_cur_r[3:0] : attr_cur_r[7:4];
    end
  end

  // Blink timebase: advances once per frame on the first blank line.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 5'd0;
    end else if ((hx == H_LAST_C) && (vy == V_FRAME_C)) begin
      frame_cnt_r <= frame_cnt_r + 5'd1;
    end
  end

  // Output registers: blanking and sync share one cycle of delay so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_irgb_r  <= 4'd0;
      vga_hsync_r <= 1'b1;
      vga_vsync_r <= 1'b1;
    end else begin
      vga_irgb_r  <= n_pixel_ena ? 4'd0 : pix_r;
      vga_hsync_r <= hsync_in;
      vga_vsync_r <= vsync_in;
    end
  end

  assign vram_addr = vram_addr_r;
  assign font_addr = {char_q_r, scan_r};
  assign vga_irgb  = vga_irgb_r;
  assign vga_hsync = vga_hsync_r;
  assign vga_vsync = vga_vsync_r;

endmodule

// File: tb/tb_vga_char_pipe.sv
// Bench for vga_char_pipe: drives hx/vy sweeps, emulates the async RAMs/ROM and compares the
// outputs with a cell/bit-level reference model of the text pipeline.
module tb_vga_char_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hx, vy;
  logic        n_pixel_ena, hsync_in, vsync_in;
  logic [11:0] vram_addr, font_addr;
  logic [7:0]  text_d, color_d, font_d;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [3:0]  vga_irgb;
  logic        vga_hsync, vga_vsync;

  logic [7:0] text_mem [4096];
  logic [7:0] color_mem[4096];
  logic [7:0] font_mem [4096];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [9:0] seed_vy = 10'd0;
  int         frame = 0;
  bit         line_valid = 1'b0;
  logic [3:0] exp_irgb = 4'd0;
  logic       exp_hs = 1'b1, exp_vs = 1'b1;
  bit         pix_chk = 1'b0, sync_chk = 1'b0;

  vga_char_pipe dut (
    .clk(clk), .rst(rst), .hx(hx), .vy(vy), .n_pixel_ena(n_pixel_ena),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .vram_addr(vram_addr),
    .text_d(text_d), .color_d(color_d), .font_addr(font_addr), .font_d(font_d),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .vga_irgb(vga_irgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  always #5 clk = ~clk;

  assign text_d  = text_mem[vram_addr];
  assign color_d = color_mem[vram_addr];
  assign font_d  = font_mem[font_addr];

  // Pixel that should sit in the pixel stage while hx==h, for the currently seeded line.
  function automatic logic [3:0] model_pix(input int h);
    int c, k, row, scan, a;
    logic [7:0] ch, at, g;
    c    = (h - 8) / 8;
    k    = (h - 8) % 8;
    row  = (int'(seed_vy) / 16) % 32;
    scan = int'(seed_vy) % 16;
    a    = row * 80 + c;
    ch   = text_mem[a];
    at   = color_mem[a];
    g    = font_mem[int'(ch) * 16 + scan];
    if (cursor_en && frame >= 16 && c == int'(cursor_col) && row == int'(cursor_row) && scan >= 14)
      g = 8'hFF;
    return g[7 - k] ? at[3:0] : at[7:4];
  endfunction

  task automatic drive(input int h, input int v);
    hx          = 10'(h);
    vy          = 10'(v);
    n_pixel_ena = !(h >= 8 && h <= 647 && v < 480);
    hsync_in    = !(h >= 664 && h <= 759);
    vsync_in    = !(v == 490 || v == 491);
    @(negedge clk);
  endtask

  // Predict what the next edge produces, then take that edge.
  task automatic adv();
    sync_chk = 1'b1;
    if (rst) begin
      exp_hs = 1'b1; exp_vs = 1'b1; exp_irgb = 4'd0; pix_chk = 1'b1;
      frame = 0; line_valid = 1'b0;
    end else begin
      exp_hs = hsync_in;
      exp_vs = vsync_in;
      if (n_pixel_ena) begin
        exp_irgb = 4'd0; pix_chk = 1'b1;
      end else if (line_valid && hx >= 10'd8 && hx <= 10'd647) begin
        exp_irgb = model_pix(int'(hx)); pix_chk = 1'b1;
      end else begin
        pix_chk = 1'b0;
      end
      if (hx == 10'd799) begin
        seed_vy = vy;
        line_valid = 1'b1;
        if (vy == 10'd480) frame = (frame + 1) % 32;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic seed(input int v);
    drive(799, v);
    adv();
  endtask

  task automatic bump_frames(input int n);
    for (int i = 0; i < n; i++) seed(480);
  endtask

  task automatic randomize_mems();
    for (int i = 0; i < 4096; i++) begin
      text_mem[i]  = 8'($urandom);
      color_mem[i] = 8'($urandom);
      font_mem[i]  = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      hx = 10'($urandom_range(0, 799));
      vy = 10'($urandom_range(0, 524));
      n_pixel_ena = 1'($urandom_range(0, 1));
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      if (n == 0) begin
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
        checks++;
        if (vga_irgb !== 4'd0 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
          errors++;
          $display("FAIL reset_out got irgb=%h hs=%b vs=%b want 0 1 1", vga_irgb, vga_hsync, vga_vsync);
        end
        checks++;
        if (vram_addr !== 12'd0 || font_addr !== 12'd0) begin
          errors++;
          $display("FAIL reset_addr got vram=%0d font=%h want 0 0", vram_addr, font_addr);
        end
        adv();
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_glyph();
    logic [7:0] glyph;
    logic [3:0] want;
    randomize_mems();
    text_mem[0] = 8'h41; color_mem[0] = 8'h1E; font_mem[12'h410] = 8'hA5;
    glyph = 8'hA5;
    seed(0);
    for (int h = 0; h < 800; h++) begin
      drive(h, 0);
      if (h >= 4 && h <= 7) begin
        checks++;
        if (font_addr !== 12'h410) begin
          errors++;
          $display("FAIL basic_font_addr hx=%0d got %h want 410", h, font_addr);
        end
      end
      if (h >= 9 && h <= 16) begin
        want = glyph[16 - h] ? 4'hE : 4'h1;
        checks++;
        if (vga_irgb !== want) begin
          errors++;
          $display("FAIL basic_pixel hx=%0d got %h want %h", h, vga_irgb, want);
        end
      end
      adv();
    end
  endtask

  task automatic test_addr_sweep();
    int base, want;
    base = (467 / 16) * 80;
    seed(467);
    for (int h = 0; h < 800; h++) begin
      drive(h, 467);
      if (h < 8)        want = base;
      else if (h < 632) want = base + h / 8;
      else              want = base + 79;
      checks++;
      if (int'(vram_addr) != want) begin
        errors++;
        $display("FAIL addr_sweep hx=%0d got %0d want %0d", h, vram_addr, want);
      end
      if (h == 400) begin
        checks++;
        if (font_addr[3:0] !== 4'd3) begin
          errors++;
          $display("FAIL addr_scan got %0d want 3", font_addr[3:0]);
        end
      end
      adv();
    end
  endtask

  task automatic test_blanking();
    logic want_hs;
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'hFF; color_mem[i] = 8'hF0; font_mem[i] = 8'hFF;
    end
    seed(100);
    for (int l = 0; l < 3; l++) begin
      int v;
      v = (l == 0) ? 100 : (l == 1) ? 480 : 490;
      for (int h = 0; h < 800; h++) begin
        drive(h, v);
        checks++;
        if (vga_irgb !== 4'd0) begin
          errors++;
          $display("FAIL blank_pixel vy=%0d hx=%0d got %h want 0", v, h, vga_irgb);
        end
        if (l == 0 && h > 0) begin
          want_hs = !(h >= 665 && h <= 760);
          checks++;
          if (vga_hsync !== want_hs) begin
            errors++;
            $display("FAIL blank_hsync hx=%0d got %b want %b", h, vga_hsync, want_hs);
          end
        end
        if (sync_chk) begin
          checks++;
          if ({vga_hsync, vga_vsync} !== {exp_hs, exp_vs}) begin
            errors++;
            $display("FAIL blank_sync vy=%0d hx=%0d got %b%b want %b%b", v, h, vga_hsync, vga_vsync, exp_hs, exp_vs);
          end
        end
        adv();
      end
    end
  endtask

  task automatic cursor_line(input int v, input logic [3:0] want, input string tag);
    seed(v);
    for (int h = 0; h < 800; h++) begin
      drive(h, v);
      if (h >= 49 && h <= 56) begin
        checks++;
        if (vga_irgb !== want) begin
          errors++;
          $display("FAIL %s hx=%0d got %h want %h", tag, h, vga_irgb, want);
        end
      end
      adv();
    end
  endtask

  task automatic setup_cursor_cell();
    text_mem[2 * 80 + 5] = 8'h00;
    color_mem[2 * 80 + 5] = 8'h07;
    for (int s = 0; s < 16; s++) font_mem[s] = 8'h00;
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
  endtask

  task automatic test_cursor();
    randomize_mems();
    setup_cursor_cell();
    bump_frames(16);
    cursor_line(46, 4'h7, "cursor_on");
    bump_frames(16);
    cursor_line(46, 4'h0, "cursor_blink_off");
    bump_frames(16);
    cursor_line(45, 4'h0, "cursor_scan13");
  endtask

  task automatic test_reset_midline();
    randomize_mems();
    setup_cursor_cell();
    seed(20);
    for (int l = 0; l < 2; l++) begin
      for (int h = 0; h < 800; h++) begin
        rst = (l == 0 && h == 300);
        drive(h, 20 + l);
        if (l == 0 && h == 301) begin
          checks++;
          if (vga_irgb !== 4'd0 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
            errors++;
            $display("FAIL midreset_out got irgb=%h hs=%b vs=%b want 0 1 1", vga_irgb, vga_hsync, vga_vsync);
          end
        end
        if (pix_chk) begin
          checks++;
          if (vga_irgb !== exp_irgb) begin
            errors++;
            $display("FAIL midreset_pixel vy=%0d hx=%0d got %h want %h", vy, h, vga_irgb, exp_irgb);
          end
        end
        adv();
      end
    end
    rst = 1'b0;
    cursor_line(46, 4'h0, "midreset_frame_zero");
  endtask

  task automatic test_random_lines();
    int v, prev_v;
    bump_frames(16);
    prev_v = 46;
    seed(prev_v);
    for (int l = 0; l < 6; l++) begin
      randomize_mems();
      v = $urandom_range(0, 29) * 16 + $urandom_range(12, 15);
      cursor_en  = 1'($urandom_range(0, 3) != 0);
      cursor_col = 7'($urandom_range(0, 85));
      cursor_row = ($urandom_range(0, 1) == 1) ? 5'(prev_v / 16) : 5'($urandom_range(0, 31));
      for (int h = 0; h < 800; h++) begin
        drive(h, v);
        if (pix_chk) begin
          checks++;
          if (vga_irgb !== exp_irgb) begin
            errors++;
            $display("FAIL random_pixel vy=%0d hx=%0d got %h want %h", v, h, vga_irgb, exp_irgb);
          end
        end
        if (sync_chk) begin
          checks++;
          if ({vga_hsync, vga_vsync} !== {exp_hs, exp_vs}) begin
            errors++;
            $display("FAIL random_sync vy=%0d hx=%0d got %b%b want %b%b", v, h, vga_hsync, vga_vsync, exp_hs, exp_vs);
          end
        end
        adv();
      end
      prev_v = v;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;
    hx = 10'd0; vy = 10'd0; n_pixel_ena = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'd0; color_mem[i] = 8'd0; font_mem[i] = 8'd0;
    end
    test_reset();
    test_basic_glyph();
    test_addr_sweep();
    test_blanking();
    test_cursor();
    test_reset_midline();
    test_random_lines();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
